factorial_engine_arbiter: RTL and testbench

Round-robin controller that shares one iterative factorial engine (10-bit `n` / `go` / `result` / `result_valid` datapath) among several requesters. It accepts one request at a time, launches the engine, and waits for completion. It then returns the 10-bit result, tagged with the requester's index, through a valid/ready response port. It sits between client blocks and the engine instance and drives the engine's `go`, `n` and `rst` pins exclusively.

---
 rtl/fact_ctrl_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 37 +++
 rtl/factorial_engine_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_factorial_engine_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fact_ctrl_pkg.sv
// Shared definitions for the factorial engine arbiter: datapath width,
// controller state encoding, default watchdog limit and a clog2 helper.
package fact_ctrl_pkg;

    // Operand/result width of the shared factorial engine.
    localparam int N_W = 10;

    // Default engine watchdog limit (only active with FACT_ARB_TIMEOUT_EN).
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        GUARD = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } fact_arb_state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: selects the first asserted request at or
// after ptr, wrapping around. Produces a one-hot grant and its encoded index.
module rr_arbiter
    import fact_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    // Two passes: indices at/after ptr first, then the wrapped indices below ptr.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (i < int'(ptr))) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/factorial_engine_arbiter.sv
// Round-robin controller sharing one iterative factorial engine among
// NUM_REQ requesters. One request is outstanding at a time: grant, launch
// the engine, wait for completion, return the tagged result.
// Optional engine watchdog: define FACT_ARB_TIMEOUT_EN.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Requesters hold req_valid/req_n stable until granted; the
// controller holds resp_valid/resp_id/resp_result/resp_error stable until
// resp_ready. ready never depends on the same port's valid dropping.
module factorial_engine_arbiter
    import fact_ctrl_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int ID_W           = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*N_W-1:0] req_n,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [N_W-1:0]         resp_result,
    output logic                   resp_error,
    output logic                   eng_rst,
    output logic                   eng_go,
    output logic [N_W-1:0]         eng_n,
    input  logic [N_W-1:0]         eng_result,
    input  logic                   eng_result_valid,
    output fact_arb_state_t        dbg_state,
    output logic [ID_W-1:0]        dbg_rr_ptr
);

    fact_arb_state_t      state;
    fact_arb_state_t      next_state;
    logic [ID_W-1:0]      rr_ptr;
    logic [N_W-1:0]       op_n;
    logic [ID_W-1:0]      op_id;
    logic [N_W-1:0]       res_q;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [ID_W-1:0]      arb_idx;
    logic                 arb_any;
    logic [N_W-1:0]       sel_n;
    logic                 accept;
    logic                 timeout_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Operand of the granted requester.
    always_comb begin
        sel_n = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_n = req_n[i*N_W +: N_W];
            end
        end
    end

    // A grant in IDLE is always a handshake because ready mirrors the pick.
    assign accept = (state == IDLE) && arb_any;

    // Next-state decode and per-state handshake/engine strobes.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        resp_valid = 1'b0;
        eng_go     = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    req_ready = arb_grant;
                end
                if (arb_any) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                eng_go     = 1'b1;
                next_state = GUARD;
            end
            GUARD: begin
                // The engine may still show the previous result here.
                next_state = WAIT;
            end
            WAIT: begin
                if (eng_result_valid || timeout_hit) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request latch, round-robin pointer and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            op_n   <= '0;
            op_id  <= '0;
            res_q  <= '0;
        end else begin
            if (accept) begin
                op_n   <= sel_n;
                op_id  <= arb_idx;
                rr_ptr <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            end
            if ((state == WAIT) && eng_result_valid) begin
                res_q <= eng_result;
            end else if (timeout_hit) begin
                res_q <= '0;
            end
        end
    end

`ifdef FACT_ARB_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] wd_cnt;
    logic             err_q;

    // Counter value 0 in GUARD, so the limit covers GUARD plus WAIT cycles.
    assign timeout_hit = (state == WAIT) && !eng_result_valid &&
                         (wd_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter and error flag for the current response.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wd_cnt <= '0;
            end else if ((state == GUARD) || (state == WAIT)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if ((state == WAIT) && eng_result_valid) begin
                err_q <= 1'b0;
            end else if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign resp_error = err_q;
`else
    logic unused_cfg;

    assign unused_cfg  = ^TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
    assign resp_error  = 1'b0;
`endif

    // A watchdog expiry also resets the engine for exactly that cycle.
    assign eng_rst     = rst | timeout_hit;
    assign eng_n       = op_n;
    assign resp_id     = op_id;
    assign resp_result = res_q;
    assign dbg_state   = state;
    assign dbg_rr_ptr  = rr_ptr;

endmodule

// File: tb/tb_factorial_engine_arbiter.sv
// Directed bench for factorial_engine_arbiter with a behavioural iterative
// factorial engine. Expected results are hand-computed constants.
module tb_factorial_engine_arbiter;
    import fact_ctrl_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*N_W-1:0] req_n;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [ID_W-1:0]        resp_id;
    logic [N_W-1:0]         resp_result;
    logic                   resp_error;
    logic                   eng_rst;
    logic                   eng_go;
    logic [N_W-1:0]         eng_n;
    logic [N_W-1:0]         eng_result;
    logic                   eng_result_valid;
    fact_arb_state_t        dbg_state;
    logic [ID_W-1:0]        dbg_rr_ptr;

    int n_vec = 0;
    int n_err = 0;

    // clock / reset block
    always #5 clk = ~clk;

    factorial_engine_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_n            (req_n),
        .req_ready        (req_ready),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_id          (resp_id),
        .resp_result      (resp_result),
        .resp_error       (resp_error),
        .eng_rst          (eng_rst),
        .eng_go           (eng_go),
        .eng_n            (eng_n),
        .eng_result       (eng_result),
        .eng_result_valid (eng_result_valid),
        .dbg_state        (dbg_state),
        .dbg_rr_ptr       (dbg_rr_ptr)
    );

    // behavioural engine: one multiply per cycle, valid held until next go
    logic [N_W-1:0] e_acc = '0;
    logic [N_W-1:0] e_cnt = '0;
    logic           e_busy = 1'b0;
    logic           e_valid = 1'b0;
    logic [N_W-1:0] e_result = '0;
    logic           e_stale = 1'b0;
    logic           stale_mode = 1'b0;
    logic           hang_mode = 1'b0;
    int             go_count = 0;
    int             eng_rst_pulses = 0;

    assign eng_result       = e_result;
    assign eng_result_valid = e_valid;

    always @(posedge clk) begin
        if (eng_rst) begin
            e_busy   <= 1'b0;
            e_valid  <= 1'b0;
            e_result <= '0;
            e_stale  <= 1'b0;
            e_acc    <= '0;
            e_cnt    <= '0;
        end else if (eng_go) begin
            e_acc  <= 10'd1;
            e_cnt  <= eng_n;
            e_busy <= ~hang_mode;
            if (stale_mode) begin
                e_valid  <= 1'b1;
                e_result <= 10'h2AA;
                e_stale  <= 1'b1;
            end else begin
                e_valid <= 1'b0;
            end
        end else begin
            if (e_stale) begin
                e_valid <= 1'b0;
                e_stale <= 1'b0;
            end
            if (e_busy) begin
                if (e_cnt <= 10'd1) begin
                    e_valid  <= 1'b1;
                    e_result <= e_acc;
                    e_busy   <= 1'b0;
                end else begin
                    e_acc <= 10'(e_acc * e_cnt);
                    e_cnt <= e_cnt - 10'd1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (eng_go) go_count <= go_count + 1;
        if (eng_rst && !rst) eng_rst_pulses <= eng_rst_pulses + 1;
    end

    // comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks: everything happens 1 time unit after the falling edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grant(input string tag, input logic [NUM_REQ-1:0] exp_grant);
        int k;
        k = 0;
        while (req_ready == '0 && k < 50) begin
            tick();
            k++;
        end
        check({tag, "_grant"}, 32'(req_ready), 32'(exp_grant));
    endtask

    task automatic wait_resp(input string tag);
        int k;
        k = 0;
        while (!resp_valid && k < 200) begin
            tick();
            k++;
        end
        check({tag, "_resp_seen"}, 32'(resp_valid), 32'd1);
    endtask

    task automatic get_resp(input string tag, input int id, input logic [N_W-1:0] res);
        wait_resp(tag);
        check({tag, "_id"}, 32'(resp_id), 32'(id));
        check({tag, "_result"}, 32'(resp_result), 32'(res));
        check({tag, "_error"}, 32'(resp_error), 32'd0);
        tick();
        check({tag, "_resp_done"}, 32'(resp_valid), 32'd0);
    endtask

    logic [N_W-1:0] exp_res [4];
    int             g0;
    int             p0;
    int             k;

    initial begin
        exp_res = '{10'd24, 10'd120, 10'd720, 10'd944};
        rst        = 1'b1;
        req_valid  = '0;
        req_n      = '0;
        resp_ready = 1'b1;

        // reset state
        tick();
        tick();
        check("rst_eng_rst", 32'(eng_rst), 32'd1);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_result", 32'(resp_result), 32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        check("rst_eng_go", 32'(eng_go), 32'd0);
        check("rst_eng_n", 32'(eng_n), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_rr_ptr", 32'(dbg_rr_ptr), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_release_eng_rst", 32'(eng_rst), 32'd0);

        // single request: requester 0, n=4 -> 24, with cycle-exact sequencing
        req_n[9:0] = 10'd4;
        req_valid  = 4'b0001;
        #1;
        check("single_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;
        check("single_go", 32'(eng_go), 32'd1);
        check("single_eng_n", 32'(eng_n), 32'd4);
        check("single_ready_busy", 32'(req_ready), 32'd0);
        tick();
        check("single_go_pulse", 32'(eng_go), 32'd0);
        check("single_guard", 32'(dbg_state), 32'(GUARD));
        check("single_eng_n_hold", 32'(eng_n), 32'd4);
        tick();
        check("single_wait", 32'(dbg_state), 32'(WAIT));
        k = 0;
        while (!eng_result_valid && k < 100) begin
            tick();
            k++;
        end
        check("single_no_early_resp", 32'(resp_valid), 32'd0);
        tick();
        check("single_resp_latency", 32'(resp_valid), 32'd1);
        check("single_id", 32'(resp_id), 32'd0);
        check("single_result", 32'(resp_result), 32'd24);
        check("single_error", 32'(resp_error), 32'd0);
        tick();
        check("single_idle", 32'(dbg_state), 32'(IDLE));
        check("single_rr_ptr", 32'(dbg_rr_ptr), 32'd1);

        // short reset rewinds the pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rewind_rr_ptr", 32'(dbg_rr_ptr), 32'd0);

        // all four requesters: strict rotation 0,1,2,3
        req_n     = {10'd7, 10'd6, 10'd5, 10'd4};
        req_valid = 4'hF;
        #1;
        for (int i = 0; i < 4; i++) begin
            wait_grant($sformatf("rr%0d", i), 4'(1 << i));
            tick();
            req_valid[i] = 1'b0;
            get_resp($sformatf("rr%0d", i), i, exp_res[i]);
        end

        // backpressure: requester 1, n=5 -> 120 held for 10 cycles
        resp_ready   = 1'b0;
        req_n[19:10] = 10'd5;
        req_valid    = 4'b0010;
        #1;
        wait_grant("bp", 4'b0010);
        tick();
        g0           = go_count;
        req_valid    = 4'b0001;
        req_n[9:0]   = 10'd1;
        wait_resp("bp");
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_id", 32'(resp_id), 32'd1);
            check("bp_result", 32'(resp_result), 32'd120);
            check("bp_ready_low", 32'(req_ready), 32'd0);
            tick();
        end
        check("bp_single_go", 32'(go_count - g0), 32'd1);
        resp_ready = 1'b1;
        tick();
        check("bp_released", 32'(resp_valid), 32'd0);
        check("bp_next_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        get_resp("n1", 0, 10'd1);

        // n=0 with a stale engine valid held through GUARD
        stale_mode    = 1'b1;
        req_n[39:30]  = 10'd0;
        req_valid     = 4'b1000;
        #1;
        wait_grant("stale", 4'b1000);
        tick();
        req_valid = '0;
        get_resp("stale", 3, 10'd1);
        stale_mode = 1'b0;

        // reset while in WAIT
        req_n[9:0] = 10'd7;
        req_valid  = 4'b0001;
        #1;
        wait_grant("rstw", 4'b0001);
        tick();
        req_valid = '0;
        tick();
        tick();
        check("rstw_in_wait", 32'(dbg_state), 32'(WAIT));
        rst = 1'b1;
        tick();
        check("rstw_eng_rst0", 32'(eng_rst), 32'd1);
        check("rstw_no_resp0", 32'(resp_valid), 32'd0);
        tick();
        check("rstw_eng_rst1", 32'(eng_rst), 32'd1);
        check("rstw_no_resp1", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("rstw_quiet_resp", 32'(resp_valid), 32'd0);
        end
        check("rstw_eng_rst_off", 32'(eng_rst), 32'd0);
        check("rstw_rr_ptr", 32'(dbg_rr_ptr), 32'd0);
        check("rstw_idle", 32'(dbg_state), 32'(IDLE));
        req_n[29:20] = 10'd5;
        req_valid    = 4'b0100;
        #1;
        wait_grant("after_rst", 4'b0100);
        tick();
        req_valid = '0;
        get_resp("after_rst", 2, 10'd120);

`ifdef FACT_ARB_TIMEOUT_EN
        // engine never completes: one eng_rst pulse, error response
        hang_mode    = 1'b1;
        p0           = eng_rst_pulses;
        req_n[19:10] = 10'd3;
        req_valid    = 4'b0010;
        #1;
        wait_grant("wd", 4'b0010);
        tick();
        req_valid = '0;
        wait_resp("wd");
        check("wd_id", 32'(resp_id), 32'd1);
        check("wd_error", 32'(resp_error), 32'd1);
        check("wd_result", 32'(resp_result), 32'd0);
        check("wd_rst_pulse", 32'(eng_rst_pulses - p0), 32'd1);
        tick();
        hang_mode    = 1'b0;
        req_n[29:20] = 10'd3;
        req_valid    = 4'b0100;
        #1;
        wait_grant("wd_next", 4'b0100);
        tick();
        req_valid = '0;
        get_resp("wd_next", 2, 10'd6);
`else
        p0 = eng_rst_pulses;
        check("no_wd_rst_pulses", 32'(p0), 32'd0);
`endif

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
